// File: rtl/fix_query_pkg.sv
// Shared types and default widths for the FIX query arbiter and the parser top.
package fix_query_pkg;

  localparam int TAG_WIDTH   = 32;
  localparam int VALUE_WIDTH = 256;
  localparam int NUM_MESSAGE = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } query_state_t;

endpackage

// File: rtl/fix_query_arbiter_if.sv
// Client-side and search-path bundle of the query arbiter.
// The arbiter uses the slave modport; the clients/search-path model use master.
interface fix_query_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int TAG_WIDTH   = fix_query_pkg::TAG_WIDTH,
  parameter int VALUE_WIDTH = fix_query_pkg::VALUE_WIDTH,
  parameter int NUM_MESSAGE = fix_query_pkg::NUM_MESSAGE
);

  // Client side
  logic [NUM_REQ-1:0]             req_i;
  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag_i;
  logic [NUM_REQ*NUM_MESSAGE-1:0] req_msg_i;
  logic [NUM_REQ-1:0]             ack_o;
  logic [VALUE_WIDTH-1:0]         resp_value_o;
  logic                           resp_hit_o;

  // Search-path side
  logic [TAG_WIDTH-1:0]           find_tag_o;
  logic [NUM_MESSAGE-1:0]         message_num_o;
  logic                           read_message_o;
  logic [VALUE_WIDTH-1:0]         value_i;
  logic                           value_valid_i;

  // Status
  logic                           busy_o;

  modport slave (
    input  req_i, req_tag_i, req_msg_i, value_i, value_valid_i,
    output ack_o, resp_value_o, resp_hit_o, find_tag_o, message_num_o,
           read_message_o, busy_o
  );

  modport master (
    output req_i, req_tag_i, req_msg_i, value_i, value_valid_i,
    input  ack_o, resp_value_o, resp_hit_o, find_tag_o, message_num_o,
           read_message_o, busy_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority select: grants the first asserted request
// at or after ptr_i, wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int IW = $clog2(N);

  // Scan N candidates starting at the pointer; the first hit wins.
  always_comb begin
    logic          found;
    logic [IW:0]   cand;
    // NOTE: every output gets a default before the loop, so no path leaves a value unassigned and no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(off);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req_i[cand[IW-1:0]]) begin
        found                 = 1'b1;
        gnt_o[cand[IW-1:0]]   = 1'b1;
        idx_o                 = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fix_query_arbiter.sv
// Shares the tag-search / value-RAM read path among NUM_REQ query clients.
// Round-robin grant, one launch pulse per transaction, bounded wait for the
// value strobe, and a one-cycle ack with value and hit flag to the winner.
module fix_query_arbiter
  import fix_query_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TAG_WIDTH   = fix_query_pkg::TAG_WIDTH,
  parameter int VALUE_WIDTH = fix_query_pkg::VALUE_WIDTH,
  parameter int NUM_MESSAGE = fix_query_pkg::NUM_MESSAGE,
  parameter int TIMEOUT     = 15
) (
  input logic                clk,
  input logic                rst,
  fix_query_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  query_state_t           state_q;
  logic [IW-1:0]          rr_ptr_q;
  logic [IW-1:0]          gnt_idx_q;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [CW-1:0]          wait_cnt_q;
  logic [TAG_WIDTH-1:0]   find_tag_q;
  logic [NUM_MESSAGE-1:0] message_num_q;
  logic                   read_message_q;
  logic [NUM_REQ-1:0]     ack_q;
  logic [VALUE_WIDTH-1:0] resp_value_q;
  logic                   resp_hit_q;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IW-1:0]          arb_idx;
  logic [TAG_WIDTH-1:0]   find_tag_d;
  logic [NUM_MESSAGE-1:0] message_num_d;
  logic [IW-1:0]          rr_ptr_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req_i (bus.req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Request fields of the client the arbiter would grant, and the pointer past the current grant.
  always_comb begin
    find_tag_d    = bus.req_tag_i[arb_idx*TAG_WIDTH +: TAG_WIDTH];
    message_num_d = bus.req_msg_i[arb_idx*NUM_MESSAGE +: NUM_MESSAGE];
    rr_ptr_d      = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IW'(1);
  end

  // Transaction FSM with registered launch, ack and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      gnt_idx_q      <= '0;
      gnt_q          <= '0;
      wait_cnt_q     <= '0;
      find_tag_q     <= '0;
      message_num_q  <= '0;
      read_message_q <= 1'b0;
      ack_q          <= '0;
      // NOTE: the wide value register is reset on purpose: the response bus must read 0 after reset.
      resp_value_q   <= '0;
      resp_hit_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge register values.
      read_message_q <= 1'b0;
      ack_q          <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|bus.req_i) begin
            gnt_idx_q      <= arb_idx;
            gnt_q          <= arb_gnt;
            find_tag_q     <= find_tag_d;
            message_num_q  <= message_num_d;
            read_message_q <= 1'b1;
            state_q        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A strobe in the timeout cycle still counts as a hit.
          if (bus.value_valid_i) begin
            resp_value_q <= bus.value_i;
            resp_hit_q   <= 1'b1;
            ack_q        <= gnt_q;
            state_q      <= ST_RESP;
          end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            resp_value_q <= '0;
            resp_hit_q   <= 1'b0;
            ack_q        <= gnt_q;
            state_q      <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.find_tag_o     = find_tag_q;
  assign bus.message_num_o  = message_num_q;
  assign bus.read_message_o = read_message_q;
  assign bus.ack_o          = ack_q;
  assign bus.resp_value_o   = resp_value_q;
  assign bus.resp_hit_o     = resp_hit_q;
  assign bus.busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fix_query_arbiter.sv
// Directed bench for fix_query_arbiter: stimulus pushes expected responses
// into a queue, a negedge monitor pops and compares whenever ack_o fires.
module tb_fix_query_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TW      = fix_query_pkg::TAG_WIDTH;
  localparam int VW      = fix_query_pkg::VALUE_WIDTH;
  localparam int MW      = fix_query_pkg::NUM_MESSAGE;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic [NUM_REQ-1:0] ack;
    logic [VW-1:0]      value;
    logic               hit;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fix_query_arbiter_if #(
    .NUM_REQ(NUM_REQ), .TAG_WIDTH(TW), .VALUE_WIDTH(VW), .NUM_MESSAGE(MW)
  ) bus ();

  fix_query_arbiter #(
    .NUM_REQ(NUM_REQ), .TAG_WIDTH(TW), .VALUE_WIDTH(VW), .NUM_MESSAGE(MW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   cyc     = 0;
  int   ack_cyc = -1;
  int   rd_cnt  = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Edge counter: after edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count launch pulses, score every ack against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (bus.read_message_o) rd_cnt++;
    if (bus.ack_o != '0) begin
      ack_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got %b want none", bus.ack_o);
      end else begin
        e = exp_q.pop_front();
        check("ack_onehot", VW'(bus.ack_o), VW'(e.ack));
        check("resp_value", bus.resp_value_o, e.value);
        check("resp_hit",   VW'(bus.resp_hit_o), VW'(e.hit));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int k, input logic [TW-1:0] tag, input logic [MW-1:0] msg);
    bus.req_tag_i[k*TW +: TW] = tag;
    bus.req_msg_i[k*MW +: MW] = msg;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},      VW'(bus.ack_o), '0);
    check({tag, "_value"},    bus.resp_value_o, '0);
    check({tag, "_hit"},      VW'(bus.resp_hit_o), '0);
    check({tag, "_find_tag"}, VW'(bus.find_tag_o), '0);
    check({tag, "_msg"},      VW'(bus.message_num_o), '0);
    check({tag, "_read"},     VW'(bus.read_message_o), '0);
    check({tag, "_busy"},     VW'(bus.busy_o), '0);
    check({tag, "_rr_ptr"},   VW'(dut.rr_ptr_q), '0);
  endtask

  // One transaction from a single client, started from IDLE.
  // vdelay: WAIT cycle index in which value_valid_i is driven (<0: never).
  task automatic run_txn(input int k, input logic [TW-1:0] tag, input logic [MW-1:0] msg,
                         input int vdelay, input logic [VW-1:0] val, input bit drop_in_wait);
    exp_t e;
    bit   hit;
    int   t0;
    int   rd0;
    int   lat_exp;
    hit     = (vdelay >= 0) && (vdelay < TIMEOUT);
    e.ack   = NUM_REQ'(1) << k;
    e.value = hit ? val : '0;
    e.hit   = hit;
    exp_q.push_back(e);
    set_client(k, tag, msg);
    bus.req_i[k] = 1'b1;
    rd0     = rd_cnt;
    ack_cyc = -1;
    step();                       // edge t0 samples the request
    t0 = cyc;
    check("issue_read", VW'(bus.read_message_o), VW'(1'b1));
    check("issue_tag",  VW'(bus.find_tag_o), VW'(tag));
    check("issue_msg",  VW'(bus.message_num_o), VW'(msg));
    step();                       // first WAIT cycle
    if (drop_in_wait) bus.req_i[k] = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (i == vdelay) begin
        bus.value_valid_i = 1'b1;
        bus.value_i       = val;
      end
      step();
      bus.value_valid_i = 1'b0;
      bus.value_i       = '0;
      if (i == vdelay) break;
    end
    bus.req_i[k] = 1'b0;          // RESP cycle: client drops its request
    step();
    step();
    lat_exp = hit ? 3 + vdelay : 2 + TIMEOUT;
    check("ack_latency", VW'(ack_cyc - t0 + 1), VW'(lat_exp));
    check("read_pulses", VW'(rd_cnt - rd0), VW'(1));
    check("back_idle",   VW'(bus.busy_o), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   rd0;
    int   waited;
    rst               = 1'b1;
    bus.req_i         = '0;
    bus.req_tag_i     = '0;
    bus.req_msg_i     = '0;
    bus.value_i       = '0;
    bus.value_valid_i = 1'b0;
    step();
    step();
    check_all_zero("reset");
    check("reset_wait_cnt", VW'(dut.wait_cnt_q), '0);
    rst = 1'b0;
    step();

    // Single hit: client 1, valid in the first WAIT cycle.
    run_txn(1, 32'h0000_0023, 10'd3, 0, 256'hABCD, 1'b0);

    // Round-robin: re-reset so the pointer starts at 0, then hold all four high.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < NUM_REQ; k++) set_client(k, TW'(32'h100 + k), MW'(k));
    bus.req_i = '1;
    for (int n = 0; n < 5; n++) begin
      e.ack   = NUM_REQ'(1) << (n % NUM_REQ);
      e.value = VW'(256'h5000 + n);
      e.hit   = 1'b1;
      exp_q.push_back(e);
      waited = 0;
      while (!bus.read_message_o && waited < 20) begin
        step();
        waited++;
      end
      check("rr_launch_seen", VW'(bus.read_message_o), VW'(1'b1));
      check("rr_find_tag", VW'(bus.find_tag_o), VW'(32'h100 + (n % NUM_REQ)));
      step();
      bus.value_valid_i = 1'b1;
      bus.value_i       = VW'(256'h5000 + n);
      step();
      bus.value_valid_i = 1'b0;
      bus.value_i       = '0;
      if (n == 4) bus.req_i = '0;
    end
    step();
    step();
    check("rr_idle", VW'(bus.busy_o), '0);
    // Pointer is now 1 (last grant was client 0).

    // Timeout miss: no strobe at all.
    run_txn(2, 32'h0000_0044, 10'd7, -1, 256'hDEAD, 1'b0);

    // Strobe in the very cycle the timeout is reached: still a hit.
    run_txn(1, 32'h0000_0055, 10'd9, TIMEOUT - 1, 256'h1234_5678, 1'b0);

    // Stray strobe in IDLE: ignored, no ack, no launch.
    rd0 = rd_cnt;
    bus.value_valid_i = 1'b1;
    bus.value_i       = VW'(256'hBAD);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stray_idle_busy", VW'(bus.busy_o), '0);
    end
    bus.value_valid_i = 1'b0;
    bus.value_i       = '0;
    step();
    check("stray_no_launch", VW'(rd_cnt - rd0), '0);

    // Reset mid-WAIT (pointer is 2 beforehand): all outputs clear immediately.
    set_client(0, 32'h0000_0077, 10'd1);
    bus.req_i[0] = 1'b1;
    step();
    bus.req_i[0] = 1'b0;
    step();
    step();
    check("pre_reset_busy", VW'(bus.busy_o), VW'(1'b1));
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    step();
    step();
    rst = 1'b0;
    step();
    run_txn(2, 32'h0000_0088, 10'd2, 1, 256'hCAFE, 1'b0);

    // Withdrawn request: client 3 drops req during WAIT, still acked, not re-granted.
    run_txn(3, 32'h0000_0099, 10'd5, 2, 256'hF00D, 1'b1);
    rd0 = rd_cnt;
    for (int i = 0; i < 6; i++) step();
    check("withdrawn_no_regrant", VW'(rd_cnt - rd0), '0);
    check("withdrawn_idle", VW'(bus.busy_o), '0);

    check("scoreboard_drained", VW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
